// File: rtl/fpi_pkg.sv
// Shared types and defaults for the 5x5 bit-grid permutation sequencer.
package fpi_pkg;

    localparam int unsigned STEP_W        = 5;
    localparam int unsigned DEF_MAX_STEPS = 24;
    localparam int unsigned DEF_MAX_ADJ   = 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_INITIJ = 4'd2,
        S_READ   = 4'd3,
        S_NEXTI  = 4'd4,
        S_ADJUST = 4'd5,
        S_UPDATE = 4'd6,
        S_WRITE  = 4'd7,
        S_CHECK  = 4'd8,
        S_FINISH = 4'd9
    } fpiState_t;

    // Datapath control word plus the status strobes that decode from state.
    typedef struct packed {
        logic busy;
        logic finish;
        logic ok;
        logic initLine;
        logic firstread;
        logic IJen;
        logic IJregen;
        logic read;
        logic writeVal;
        logic writeMemReg;
        logic ldTillPositive;
        logic waitCalNexti;
        logic update;
        logic write;
        logic enable;
    } fpiCtl_t;

    // Moore decode: control word asserted while sitting in state s.
    function automatic fpiCtl_t fpiDecode(input fpiState_t s);
        fpiCtl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_LOAD:   begin c.initLine = 1'b1; c.firstread = 1'b1; c.enable = 1'b1; end
            S_INITIJ: begin c.IJen = 1'b1; c.IJregen = 1'b1; c.enable = 1'b1; end
            S_READ:   begin
                c.read        = 1'b1;
                c.writeVal    = 1'b1;
                c.writeMemReg = 1'b1;
                c.enable      = 1'b1;
            end
            S_NEXTI:  begin c.ldTillPositive = 1'b1; c.enable = 1'b1; end
            S_ADJUST: begin
                c.ldTillPositive = 1'b1;
                c.waitCalNexti   = 1'b1;
                c.enable         = 1'b1;
            end
            S_UPDATE: begin c.update = 1'b1; c.IJregen = 1'b1; c.enable = 1'b1; end
            S_WRITE:  begin c.write = 1'b1; c.enable = 1'b1; end
            S_CHECK:  c.enable = 1'b1;
            S_FINISH: begin c.ok = 1'b1; c.finish = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fpi_step_counter.sv
// Saturating step and adjust counters with synchronous clear and increment.
module fpi_step_counter #(
    parameter int unsigned STEP_W = 5,
    parameter int unsigned ADJ_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stepClr,
    input  logic              stepInc,
    input  logic              adjClr,
    input  logic              adjInc,
    output logic [STEP_W-1:0] stepCount,
    output logic [ADJ_W-1:0]  adjCount
);

    // Step counter: clear wins over increment, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stepCount <= '0;
        end else if (stepClr) begin
            stepCount <= '0;
        end else if (stepInc && (stepCount != {STEP_W{1'b1}})) begin
            stepCount <= stepCount + STEP_W'(1);
        end
    end

    // Adjust counter: per-step +5 correction count, holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            adjCount <= '0;
        end else if (adjClr) begin
            adjCount <= '0;
        end else if (adjInc && (adjCount != {ADJ_W{1'b1}})) begin
            adjCount <= adjCount + ADJ_W'(1);
        end
    end

endmodule

// File: rtl/fpi_controller.sv
// Sequencer for the 5x5 bit-grid permutation walk; sole driver of datapath controls.
module fpi_controller
    import fpi_pkg::*;
#(
    parameter int unsigned MAX_STEPS = DEF_MAX_STEPS,
    parameter int unsigned MAX_ADJ   = DEF_MAX_ADJ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              finish,
    output logic              err,
    output logic [STEP_W-1:0] step_count,
    input  logic              sign,
    input  logic              done,
    input  logic              sign3j,
    input  logic              signeq,
    input  logic              eq,
    output logic              initLine,
    output logic              firstread,
    output logic              IJen,
    output logic              IJregen,
    output logic              read,
    output logic              writeVal,
    output logic              writeMemReg,
    output logic              ldTillPositive,
    output logic              waitCalNexti,
    output logic              update,
    output logic              write,
    output logic              ok,
    output logic              enable,
    output logic              ALUop,
    output logic              isArith,
    output logic              fb3j,
    output logic              fbeq
);

    localparam int unsigned ADJ_W = $clog2(MAX_ADJ + 1);

    fpiState_t        state;
    fpiState_t        nextState;
    fpiCtl_t          ctlQ;
    logic             errQ;
    logic             errSet;
    logic             stepClr;
    logic             stepInc;
    logic             adjClr;
    logic             adjInc;
    logic [ADJ_W-1:0] adjCount;
    logic             unusedInputs;

    // Comparison-result flags from the datapath are not needed by the sequencer.
    assign unusedInputs = ^{sign3j, signeq, eq};

    fpi_step_counter #(
        .STEP_W (STEP_W),
        .ADJ_W  (ADJ_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .stepClr   (stepClr),
        .stepInc   (stepInc),
        .adjClr    (adjClr),
        .adjInc    (adjInc),
        .stepCount (step_count),
        .adjCount  (adjCount)
    );

    // State register; outputs are registered decodes of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ctlQ  <= '0;
            errQ  <= 1'b0;
        end else begin
            state <= nextState;
            ctlQ  <= fpiDecode(nextState);
            if (stepClr) begin
                errQ <= 1'b0;
            end else if (errSet) begin
                errQ <= 1'b1;
            end
        end
    end

    // Next-state logic and counter/error strobes.
    always_comb begin
        nextState = state;
        errSet    = 1'b0;
        stepClr   = 1'b0;
        stepInc   = 1'b0;
        adjClr    = 1'b0;
        adjInc    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nextState = S_LOAD;
                    stepClr   = 1'b1;
                end
            end
            S_LOAD:   nextState = S_INITIJ;
            S_INITIJ: nextState = S_READ;
            S_READ:   nextState = S_NEXTI;
            S_NEXTI: begin
                if (sign) begin
                    nextState = S_ADJUST;
                    adjClr    = 1'b1;
                end else begin
                    nextState = S_UPDATE;
                end
            end
            S_ADJUST: begin
                adjInc = 1'b1;
                if (!sign) begin
                    nextState = S_UPDATE;
                end else if (adjCount == ADJ_W'(MAX_ADJ - 1)) begin
                    errSet    = 1'b1;
                    nextState = S_FINISH;
                end
            end
            S_UPDATE: nextState = S_WRITE;
            S_WRITE: begin
                stepInc   = 1'b1;
                nextState = S_CHECK;
            end
            S_CHECK: begin
                if (done) begin
                    nextState = S_FINISH;
                end else if (step_count == STEP_W'(MAX_STEPS)) begin
                    errSet    = 1'b1;
                    nextState = S_FINISH;
                end else begin
                    nextState = S_READ;
                end
            end
            S_FINISH: nextState = S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    assign busy           = ctlQ.busy;
    assign finish         = ctlQ.finish;
    assign ok             = ctlQ.ok;
    assign initLine       = ctlQ.initLine;
    assign firstread      = ctlQ.firstread;
    assign IJen           = ctlQ.IJen;
    assign IJregen        = ctlQ.IJregen;
    assign read           = ctlQ.read;
    assign writeVal       = ctlQ.writeVal;
    assign writeMemReg    = ctlQ.writeMemReg;
    assign ldTillPositive = ctlQ.ldTillPositive;
    assign waitCalNexti   = ctlQ.waitCalNexti;
    assign update         = ctlQ.update;
    assign write          = ctlQ.write;
    assign enable         = ctlQ.enable;
    assign err            = errQ;
    assign ALUop          = 1'b0;
    assign isArith        = 1'b0;
    assign fb3j           = 1'b0;
    assign fbeq           = 1'b0;

endmodule

// File: tb/tb_fpi_controller.sv
// Scoreboard bench for fpi_controller: scheduled per-state runs plus a walk model.
module tb_fpi_controller;

    localparam int B_IDLE   = 0;
    localparam int B_LOAD   = 1;
    localparam int B_INITIJ = 2;
    localparam int B_READ   = 3;
    localparam int B_NEXTI  = 4;
    localparam int B_ADJUST = 5;
    localparam int B_UPDATE = 6;
    localparam int B_WRITE  = 7;
    localparam int B_CHECK  = 8;
    localparam int B_FINISH = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sign;
    logic       done;
    logic       sign3j;
    logic       signeq;
    logic       eq;
    logic       busy, finish, err;
    logic [4:0] step_count;
    logic       initLine, firstread, IJen, IJregen, read, writeVal, writeMemReg;
    logic       ldTillPositive, waitCalNexti, update, write, ok, enable;
    logic       ALUop, isArith, fb3j, fbeq;

    int total = 0;
    int bad   = 0;

    // Stimulus source select: scheduled values or the datapath model.
    logic  useModel = 1'b0;
    logic  schSign  = 1'b0;
    logic  schDone  = 1'b0;
    logic  mdlSign;
    logic  mdlDone;

    logic [24:0] lineInit;
    logic [24:0] mem;
    int          mi, mj, mt;
    logic        mbit;

    typedef struct {
        int st;
        bit sgn;
        bit dn;
        int steps;
        bit er;
    } sbItem_t;

    sbItem_t sbQ[$];
    int      adjPlan[];

    logic [18:0] obsCtl;

    always #5 clk = ~clk;

    assign sign   = useModel ? mdlSign : schSign;
    assign done   = useModel ? mdlDone : schDone;
    assign sign3j = 1'b1;
    assign signeq = 1'b1;
    assign eq     = 1'b1;

    assign obsCtl = {busy, finish, ok, initLine, firstread, IJen, IJregen, read,
                     writeVal, writeMemReg, ldTillPositive, waitCalNexti, update,
                     write, enable, ALUop, isArith, fb3j, fbeq};

    fpi_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .finish         (finish),
        .err            (err),
        .step_count     (step_count),
        .sign           (sign),
        .done           (done),
        .sign3j         (sign3j),
        .signeq         (signeq),
        .eq             (eq),
        .initLine       (initLine),
        .firstread      (firstread),
        .IJen           (IJen),
        .IJregen        (IJregen),
        .read           (read),
        .writeVal       (writeVal),
        .writeMemReg    (writeMemReg),
        .ldTillPositive (ldTillPositive),
        .waitCalNexti   (waitCalNexti),
        .update         (update),
        .write          (write),
        .ok             (ok),
        .enable         (enable),
        .ALUop          (ALUop),
        .isArith        (isArith),
        .fb3j           (fb3j),
        .fbeq           (fbeq)
    );

    // Datapath model: walk (i,j) -> (j, (j-3i) mod 5), moving the read bit along.
    always_ff @(posedge clk) begin
        if (rst) begin
            mi   <= 0;
            mj   <= 0;
            mt   <= 0;
            mbit <= 1'b0;
        end else begin
            if (initLine) mem <= lineInit;
            if (IJen) begin
                mi <= 3;
                mj <= 3;
            end
            if (read) mbit <= mem[5*mi + mj];
            if (ldTillPositive && !waitCalNexti) mt <= mj - 3*mi;
            if (waitCalNexti) mt <= mt + 5;
            if (update) begin
                mi <= mj;
                mj <= mt;
            end
            if (write) mem[5*mi + mj] <= mbit;
        end
    end

    assign mdlSign = (ldTillPositive && !waitCalNexti) ? ((mj - 3*mi) < 0) : ((mt + 5) < 0);
    assign mdlDone = (mi == 3) && (mj == 3);

    // Expected control vector for a state, straight from the state/output table.
    function automatic logic [18:0] expCtl(input int s);
        logic [18:0] v;
        v = '0;
        v[18] = (s != B_IDLE);
        case (s)
            B_LOAD:   begin v[15] = 1'b1; v[14] = 1'b1; v[4] = 1'b1; end
            B_INITIJ: begin v[13] = 1'b1; v[12] = 1'b1; v[4] = 1'b1; end
            B_READ:   begin v[11] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; v[4] = 1'b1; end
            B_NEXTI:  begin v[8] = 1'b1; v[4] = 1'b1; end
            B_ADJUST: begin v[8] = 1'b1; v[7] = 1'b1; v[4] = 1'b1; end
            B_UPDATE: begin v[6] = 1'b1; v[12] = 1'b1; v[4] = 1'b1; end
            B_WRITE:  begin v[5] = 1'b1; v[4] = 1'b1; end
            B_CHECK:  v[4] = 1'b1;
            B_FINISH: begin v[17] = 1'b1; v[16] = 1'b1; end
            default:  ;
        endcase
        return v;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pushItem(input int st, input bit sgn, input bit dn, input int steps, input bit er);
        sbItem_t it;
        it.st    = st;
        it.sgn   = sgn;
        it.dn    = dn;
        it.steps = steps;
        it.er    = er;
        sbQ.push_back(it);
    endtask

    // Expected cycle-by-cycle run; adjPlan[k] is the ADJUST count of step k.
    task automatic buildRun(input int nSteps, input bit endDone, input bit ovfLast);
        int n;
        pushItem(B_LOAD, 1'b1, endDone, 0, 1'b0);
        pushItem(B_INITIJ, 1'b1, endDone, 0, 1'b0);
        for (int k = 0; k < nSteps; k++) begin
            n = adjPlan[k];
            pushItem(B_READ, 1'b1, endDone, k, 1'b0);
            if (ovfLast && (k == nSteps - 1)) begin
                pushItem(B_NEXTI, 1'b1, endDone, k, 1'b0);
                for (int a = 0; a < 3; a++) pushItem(B_ADJUST, 1'b1, endDone, k, 1'b0);
                pushItem(B_FINISH, 1'b1, endDone, k, 1'b1);
                pushItem(B_IDLE, 1'b0, 1'b0, k, 1'b1);
                return;
            end
            pushItem(B_NEXTI, n > 0, endDone, k, 1'b0);
            for (int a = 0; a < n; a++) pushItem(B_ADJUST, a < n - 1, endDone, k, 1'b0);
            pushItem(B_UPDATE, 1'b1, endDone, k, 1'b0);
            pushItem(B_WRITE, 1'b1, endDone, k, 1'b0);
            pushItem(B_CHECK, 1'b1, endDone && (k == nSteps - 1), k + 1, 1'b0);
        end
        pushItem(B_FINISH, 1'b1, endDone, nSteps, !endDone);
        pushItem(B_IDLE, 1'b0, 1'b0, nSteps, !endDone);
    endtask

    // Pulse start, then pop one expectation per cycle and drive that cycle's inputs.
    task automatic runSched(input string name);
        sbItem_t it;
        int      idx;
        idx      = 0;
        useModel = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            checkVal($sformatf("%s.ctl[%0d]", name, idx), 32'(obsCtl), 32'(expCtl(it.st)));
            checkVal($sformatf("%s.steps[%0d]", name, idx), 32'(step_count), 32'(it.steps));
            checkVal($sformatf("%s.err[%0d]", name, idx), 32'(err), 32'(it.er));
            schSign = it.sgn;
            schDone = it.dn;
            idx++;
            if (sbQ.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        schSign = 1'b0;
        schDone = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  gotFin;
        bit  sawFin;

        rst      = 1'b1;
        start    = 1'b1;
        lineInit = 25'h1FFFFFF;

        // Reset held with start high: idle, everything low.
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst.ctl", 32'(obsCtl), 32'(expCtl(B_IDLE)));
        checkVal("rst.busy", 32'(busy), 32'd0);
        checkVal("rst.steps", 32'(step_count), 32'd0);
        checkVal("rst.err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkVal("rst.load", 32'(obsCtl), 32'(expCtl(B_LOAD)));
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checkVal("rst.midrun", 32'(obsCtl), 32'(expCtl(B_IDLE)));
        rst = 1'b0;
        @(posedge clk); #1;

        adjPlan = new[1];
        adjPlan[0] = 0;
        buildRun(1, 1'b1, 1'b0);
        runSched("one_step");

        adjPlan[0] = 3;
        buildRun(1, 1'b1, 1'b0);
        runSched("adj3");

        adjPlan = new[3];
        adjPlan[0] = 1;
        adjPlan[1] = 0;
        adjPlan[2] = 2;
        buildRun(3, 1'b1, 1'b0);
        runSched("mixed");

        adjPlan = new[2];
        adjPlan[0] = 0;
        adjPlan[1] = 0;
        buildRun(2, 1'b0, 1'b1);
        runSched("adj_ovf");

        adjPlan = new[1];
        adjPlan[0] = 1;
        buildRun(1, 1'b1, 1'b0);
        runSched("err_clear");

        adjPlan = new[24];
        foreach (adjPlan[k]) adjPlan[k] = 0;
        buildRun(24, 1'b0, 1'b0);
        runSched("budget");

        // Integration: walk (3,3)->(3,4)->(4,0)->(0,3)->(3,3), ADJUST counts 2,1,3,0.
        useModel = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkVal("int.load", 32'(initLine), 32'd1);
        cyc    = 1;
        gotFin = 1'b0;
        while (!gotFin && cyc < 100) begin
            start = (cyc == 10);
            @(posedge clk); #1;
            cyc++;
            if (finish) gotFin = 1'b1;
        end
        start = 1'b0;
        checkVal("int.finish", 32'(gotFin), 32'd1);
        checkVal("int.cycles", 32'(cyc), 32'd29);
        checkVal("int.err", 32'(err), 32'd0);
        checkVal("int.steps", 32'(step_count), 32'd4);
        checkVal("int.mem", 32'(mem), 32'h01FFFFFF);
        checkVal("int.ij", 32'(mi * 5 + mj), 32'd18);
        @(posedge clk); #1;
        checkVal("int.busy_drop", 32'(busy), 32'd0);

        // Reset in the middle of an integration run: no finish afterwards.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkVal("rst_int.ctl", 32'(obsCtl), 32'(expCtl(B_IDLE)));
        checkVal("rst_int.steps", 32'(step_count), 32'd0);
        sawFin = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (finish || busy) sawFin = 1'b1;
        end
        checkVal("rst_int.nofinish", 32'(sawFin), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
